// File: rtl/cp_strip_framer.sv
// Cyclic-prefix stripper / OFDM symbol framer.
// Drops CP_LEN prefix samples of every symbol, forwards FFT_LEN useful samples
// with sop/eop markers and a symbol index, and tracks symbols within a frame.
// A sync accepted mid-frame aborts the frame and restarts at CP sample 0.
module cp_strip_framer #(
    parameter int DW      = 14,
    parameter int FFT_LEN = 64,
    parameter int CP_LEN  = 16,
    parameter int NUM_SYM = 8,
    parameter int SYM_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_I,
    input  logic [DW-1:0]    in_Q,
    input  logic             sync,
    output logic             out_valid,
    output logic [DW-1:0]    out_I,
    output logic [DW-1:0]    out_Q,
    output logic             out_sop,
    output logic             out_eop,
    output logic [SYM_W-1:0] out_sym_idx,
    output logic             frame_done,
    output logic             sync_err,
    output logic             busy
);

    localparam int MAX_LEN = (FFT_LEN > CP_LEN) ? FFT_LEN : CP_LEN;
    localparam int CW      = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0]    CP_LAST  = CW'(CP_LEN - 1);
    localparam logic [CW-1:0]    FFT_LAST = CW'(FFT_LEN - 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NUM_SYM - 1);

    typedef enum logic [1:0] {
        IDLE,
        CP,
        DATA
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SYM_W-1:0] sym;

    // Framing FSM with registered outputs; sync with a valid sample has priority in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sym         <= '0;
            out_valid   <= 1'b0;
            out_I       <= '0;
            out_Q       <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_sym_idx <= '0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (in_valid) begin
                if (sync) begin
                    // This sample is CP sample 0 of symbol 0 of a new frame.
                    sync_err <= (state != IDLE);
                    sym      <= '0;
                    busy     <= 1'b1;
                    if (CP_LEN == 1) begin
                        state <= DATA;
                        cnt   <= '0;
                    end else begin
                        state <= CP;
                        cnt   <= CW'(1);
                    end
                end else begin
                    case (state)
                        IDLE: begin
                            state <= IDLE;
                        end
                        CP: begin
                            if (cnt == CP_LAST) begin
                                state <= DATA;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        DATA: begin
                            out_valid   <= 1'b1;
                            out_I       <= in_I;
                            out_Q       <= in_Q;
                            out_sym_idx <= sym;
                            out_sop     <= (cnt == '0);
                            out_eop     <= (cnt == FFT_LAST);
                            if (cnt == FFT_LAST) begin
                                cnt <= '0;
                                if (sym == SYM_LAST) begin
                                    frame_done <= 1'b1;
                                    state      <= IDLE;
                                    sym        <= '0;
                                    busy       <= 1'b0;
                                end else begin
                                    state <= CP;
                                    sym   <= sym + 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            cnt   <= '0;
                            sym   <= '0;
                            busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/cp_strip_framer.md
Name: cp_strip_framer

Overview:
- Sits directly downstream of the 4x decimating I/Q averager in the OFDM receiver.
- Takes the decimated 14-bit I/Q stream plus a per-sample valid strobe and a frame-sync pulse from timing acquisition.
- Discards the cyclic prefix of each OFDM symbol and forwards the FFT_LEN useful samples with start/end-of-symbol markers and a symbol index to the FFT input buffer.
- Tracks symbol count within a frame and flags resynchronisation events.

Parameters:
- DW, 14, I/Q sample width (two's complement).
- FFT_LEN, 64, useful samples per symbol; must be >= 2.
- CP_LEN, 16, cyclic-prefix samples per symbol; must be >= 1.
- NUM_SYM, 8, OFDM symbols per frame; must be >= 1.
- SYM_W, 3, width of out_sym_idx; must be >= clog2(NUM_SYM), minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  one-cycle strobe; the current in_I/in_Q form one decimated sample
- in_I  in  DW  decimated in-phase sample
- in_Q  in  DW  decimated quadrature sample
- sync  in  1  frame start; honoured only when in_valid=1, and that sample is CP sample 0 of symbol 0
- out_valid  out  1  output sample strobe
- out_I  out  DW  useful in-phase sample
- out_Q  out  DW  useful quadrature sample
- out_sop  out  1  first useful sample of a symbol (qualified by out_valid)
- out_eop  out  1  last useful sample of a symbol (qualified by out_valid)
- out_sym_idx  out  SYM_W  symbol index within the frame, 0..NUM_SYM-1
- frame_done  out  1  one-cycle pulse coincident with the eop of symbol NUM_SYM-1
- sync_err  out  1  one-cycle pulse when sync is accepted while a frame is in progress
- busy  out  1  high while not in IDLE

Behaviour:
- Reset is asynchronous, active-high, on clk rising edge otherwise.
  - All outputs reset to 0: out_I and out_Q are 0, and every flag is 0.
  - FSM resets to IDLE; sample counter and symbol counter reset to 0.
- FSM states: IDLE, CP, DATA. All state and outputs are registered.
- Latency: a sample accepted at edge N appears on the outputs after edge N, i.e. 1 cycle later.
- When in_valid=0, the FSM and counters hold, and out_valid, sop, eop, frame_done and sync_err are 0 that cycle. out_I/out_Q hold their last value.
- IDLE:
  - sync & in_valid: the sample counts as CP sample 0.
  - If CP_LEN==1, go to DATA with cnt=0; otherwise go to CP with cnt=1. sym=0 in both cases.
  - All other inputs are ignored.
- CP:
  - Each in_valid sample is dropped (out_valid=0).
  - If cnt==CP_LEN-1, go to DATA with cnt=0; otherwise increment cnt.
- DATA:
  - Each in_valid sample is forwarded: out_valid=1, out_I/out_Q = input, out_sym_idx = sym.
  - out_sop = (cnt==0); out_eop = (cnt==FFT_LEN-1).
  - At cnt==FFT_LEN-1 with sym==NUM_SYM-1: frame_done=1, go to IDLE, clear cnt and sym.
  - At cnt==FFT_LEN-1 with sym<NUM_SYM-1: go to CP with cnt=0 and increment sym.
  - Otherwise increment cnt.
- Resync: sync & in_valid in CP or DATA aborts the current frame.
  - sync_err pulses for 1 cycle.
  - The sample is treated exactly as in IDLE (CP sample 0 of a new frame, sym=0).
  - A truncated symbol emits no eop and no frame_done.
- sync without in_valid is ignored in every state.
- Counters never wrap beyond their terminal values. Counter width is clog2(max(FFT_LEN, CP_LEN)).
- busy=1 in CP and DATA. busy goes 0 on the edge where DATA exits to IDLE.

Test Plan:
- Reset mid-DATA (sample 30 of symbol 1), then release -> all outputs 0; ignores samples until the next sync & in_valid.
- Nominal frame, DW=14, CP_LEN=16, FFT_LEN=64, NUM_SYM=2, in_valid every 4th cycle, ramp data 0,1,2,...
  - Output values 16..79 with sop at 16 and eop at 79, sym_idx 0.
  - Output values 96..159 with sym_idx 1; frame_done coincides with eop at 159.
  - busy drops the next cycle; exactly 128 out_valid pulses in total.
- in_valid gaps: random 1-10 idle cycles between samples, same ramp -> identical output sequence; no out_valid during gaps.
- Resync at ramp value 50 (DATA, symbol 0) -> sync_err pulse.
  - Outputs 16..49 have no eop.
  - Next output is value 66 with sop, sym_idx 0.
- sync asserted with in_valid=0 in IDLE and in DATA -> no state change, no sync_err.
- CP_LEN=1, FFT_LEN=2, NUM_SYM=1, input 7,8,9 with sync on 7 -> outputs 8 (sop) and 9 (eop, frame_done); return to IDLE.
